// File: rtl/settings_pkg.sv
// Shared settings for the memory checker datapath: address width, default
// result-stage parameters, and the types exchanged with the CSR block.
package settings_pkg;

  localparam int CTRL_ADDR_W = 32;

  localparam int DEF_ERR_CNT_W      = 16;
  localparam int DEF_STAT_CNT_W     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam bit DEF_STOP_ON_ERROR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } result_state_t;

  typedef struct packed {
    logic                      error_flg;
    logic                      timeout_flg;
    logic [CTRL_ADDR_W-1:0]    first_error_addr;
    logic [DEF_ERR_CNT_W-1:0]  error_cnt;
    logic [DEF_STAT_CNT_W-1:0] checked_word_cnt;
    logic [DEF_STAT_CNT_W-1:0] test_cycle_cnt;
  } result_struct_t;

  // Watchdog counter width; a one-cycle timeout still needs a 1-bit counter.
  function automatic int idle_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping so statistics never under-report after overflow.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (rst_i || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/result_block.sv
// Final memory-checker stage: tracks the test state machine, accumulates
// verdict statistics and presents registered results to the control block.
module result_block
  import settings_pkg::*;
#(
  parameter int ERR_CNT_W      = DEF_ERR_CNT_W,
  parameter int STAT_CNT_W     = DEF_STAT_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter bit STOP_ON_ERROR  = DEF_STOP_ON_ERROR
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_test_i,
  input  logic                   trans_done_stb_i,
  input  logic                   cmp_busy_i,
  input  logic                   check_result_valid_i,
  input  logic                   check_result_i,
  input  logic [CTRL_ADDR_W-1:0] check_error_address_i,
  output logic                   test_busy_o,
  output logic                   test_done_o,
  output logic                   test_done_stb_o,
  output logic                   error_flg_o,
  output logic                   timeout_flg_o,
  output logic [CTRL_ADDR_W-1:0] first_error_addr_o,
  output logic [ERR_CNT_W-1:0]   error_cnt_o,
  output logic [STAT_CNT_W-1:0]  checked_word_cnt_o,
  output logic [STAT_CNT_W-1:0]  test_cycle_cnt_o
);

  localparam int                IDLE_W    = idle_cnt_width(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  result_state_t     state;
  logic [IDLE_W-1:0] idle_cnt;

  logic active;
  logic running;
  logic accept;
  logic err_hit;
  logic timeout_hit;
  logic end_test;
  logic enter_drain;

  // A start pulse pre-empts everything, so all events below are masked by it.
  assign active      = (state == ST_RUN) || (state == ST_DRAIN);
  assign running     = active && !start_test_i;
  assign accept      = running && check_result_valid_i;
  assign err_hit     = accept && check_result_i;
  assign timeout_hit = running && !check_result_valid_i && (idle_cnt == IDLE_LAST);
  assign end_test    = (err_hit && STOP_ON_ERROR) || timeout_hit ||
                       (running && (state == ST_DRAIN) && !cmp_busy_i);
  assign enter_drain = running && (state == ST_RUN) && trans_done_stb_i;

  sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (start_test_i),
    .inc   (err_hit),
    .cnt   (error_cnt_o)
  );

  sat_counter #(.WIDTH(STAT_CNT_W)) u_word_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (start_test_i),
    .inc   (accept),
    .cnt   (checked_word_cnt_o)
  );

  sat_counter #(.WIDTH(STAT_CNT_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (start_test_i),
    .inc   (running),
    .cnt   (test_cycle_cnt_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state              <= ST_IDLE;
      idle_cnt           <= '0;
      test_busy_o        <= 1'b0;
      test_done_o        <= 1'b0;
      test_done_stb_o    <= 1'b0;
      error_flg_o        <= 1'b0;
      timeout_flg_o      <= 1'b0;
      first_error_addr_o <= '0;
    end else begin
      test_done_stb_o <= 1'b0;
      if (start_test_i) begin
        state              <= ST_RUN;
        idle_cnt           <= '0;
        test_busy_o        <= 1'b1;
        test_done_o        <= 1'b0;
        error_flg_o        <= 1'b0;
        timeout_flg_o      <= 1'b0;
        first_error_addr_o <= '0;
      end else if (active) begin
        if (accept) begin
          idle_cnt <= '0;
        end else if (!timeout_hit) begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end

        if (err_hit) begin
          error_flg_o <= 1'b1;
          if (!error_flg_o) begin
            first_error_addr_o <= check_error_address_i;
          end
        end

        if (end_test) begin
          state           <= ST_DONE;
          test_busy_o     <= 1'b0;
          test_done_o     <= 1'b1;
          test_done_stb_o <= 1'b1;
          timeout_flg_o   <= timeout_hit;
        end else if (enter_drain) begin
          state <= ST_DRAIN;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_block.sv
// Scoreboard bench for result_block: two instances (stop-on-error and
// run-to-completion) share stimulus and are checked against a reference model.
module tb_result_block;
  import settings_pkg::*;

  localparam int     ERR_W    = 4;
  localparam int     STAT_W   = 32;
  localparam int     TO       = 16;
  localparam longint ERR_MAX  = (longint'(1) << ERR_W) - 1;
  localparam longint STAT_MAX = (longint'(1) << STAT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst = 1'b1;
  logic                   start = 1'b0, tdone = 1'b0, busy = 1'b0;
  logic                   valid = 1'b0, res = 1'b0;
  logic [CTRL_ADDR_W-1:0] addr = '0;

  logic                   s_busy, s_done, s_stb, s_eflg, s_tflg;
  logic [CTRL_ADDR_W-1:0] s_addr;
  logic [ERR_W-1:0]       s_ecnt;
  logic [STAT_W-1:0]      s_wcnt, s_ccnt;
  logic                   c_busy, c_done, c_stb, c_eflg, c_tflg;
  logic [CTRL_ADDR_W-1:0] c_addr;
  logic [ERR_W-1:0]       c_ecnt;
  logic [STAT_W-1:0]      c_wcnt, c_ccnt;

  result_block #(.ERR_CNT_W(ERR_W), .STAT_CNT_W(STAT_W), .TIMEOUT_CYCLES(TO),
                 .STOP_ON_ERROR(1'b1)) dut_stop (
    .clk_i(clk), .rst_i(rst), .start_test_i(start), .trans_done_stb_i(tdone),
    .cmp_busy_i(busy), .check_result_valid_i(valid), .check_result_i(res),
    .check_error_address_i(addr), .test_busy_o(s_busy), .test_done_o(s_done),
    .test_done_stb_o(s_stb), .error_flg_o(s_eflg), .timeout_flg_o(s_tflg),
    .first_error_addr_o(s_addr), .error_cnt_o(s_ecnt),
    .checked_word_cnt_o(s_wcnt), .test_cycle_cnt_o(s_ccnt)
  );

  result_block #(.ERR_CNT_W(ERR_W), .STAT_CNT_W(STAT_W), .TIMEOUT_CYCLES(TO),
                 .STOP_ON_ERROR(1'b0)) dut_cont (
    .clk_i(clk), .rst_i(rst), .start_test_i(start), .trans_done_stb_i(tdone),
    .cmp_busy_i(busy), .check_result_valid_i(valid), .check_result_i(res),
    .check_error_address_i(addr), .test_busy_o(c_busy), .test_done_o(c_done),
    .test_done_stb_o(c_stb), .error_flg_o(c_eflg), .timeout_flg_o(c_tflg),
    .first_error_addr_o(c_addr), .error_cnt_o(c_ecnt),
    .checked_word_cnt_o(c_wcnt), .test_cycle_cnt_o(c_ccnt)
  );

  typedef struct packed {
    logic                   eflg;
    logic                   tflg;
    logic [CTRL_ADDR_W-1:0] addr;
    logic [15:0]            ecnt;
    logic [31:0]            wcnt;
    logic [31:0]            ccnt;
  } res_t;

  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} phase_t;

  typedef struct {
    phase_t                 phase;
    longint                 words, errs, cycles;
    int                     idle;
    bit                     eflg, tflg, stb;
    logic [CTRL_ADDR_W-1:0] first;
  } model_t;

  model_t m[2];
  res_t   q_stop[$];
  res_t   q_cont[$];
  int     checks = 0;
  int     errors = 0;
  int     stb_cnt[2] = '{0, 0};
  bit     mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic res_t snap(input int k);
    res_t r;
    r.eflg = m[k].eflg;
    r.tflg = m[k].tflg;
    r.addr = m[k].first;
    r.ecnt = 16'(m[k].errs);
    r.wcnt = 32'(m[k].words);
    r.ccnt = 32'(m[k].cycles);
    return r;
  endfunction

  task automatic model_clear(input int k);
    m[k].words  = 0;
    m[k].errs   = 0;
    m[k].cycles = 0;
    m[k].idle   = 0;
    m[k].eflg   = 0;
    m[k].tflg   = 0;
    m[k].first  = '0;
  endtask

  // One clock of the behavioural model, using the inputs presented for this edge.
  task automatic model_step(input int k, input bit stop);
    bit fin;
    fin      = 0;
    m[k].stb = 0;
    if (rst) begin
      model_clear(k);
      m[k].phase = M_IDLE;
    end else if (start) begin
      model_clear(k);
      m[k].phase = M_RUN;
    end else if (m[k].phase == M_RUN || m[k].phase == M_DRAIN) begin
      if (m[k].cycles < STAT_MAX) m[k].cycles++;
      if (valid) begin
        m[k].idle = 0;
        if (m[k].words < STAT_MAX) m[k].words++;
        if (res) begin
          if (!m[k].eflg) m[k].first = addr;
          m[k].eflg = 1;
          if (m[k].errs < ERR_MAX) m[k].errs++;
          if (stop) fin = 1;
        end
      end else if (m[k].idle == TO - 1) begin
        m[k].tflg = 1;
        fin       = 1;
      end else begin
        m[k].idle++;
      end
      if (!fin && m[k].phase == M_RUN && tdone) m[k].phase = M_DRAIN;
      else if (!fin && m[k].phase == M_DRAIN && !busy) fin = 1;
      if (fin) begin
        m[k].phase = M_DONE;
        m[k].stb   = 1;
        if (k == 0) q_stop.push_back(snap(0));
        else        q_cont.push_back(snap(1));
      end
    end
  endtask

  task automatic cycle(input bit s, input bit td, input bit b, input bit v, input bit r,
                       input logic [CTRL_ADDR_W-1:0] a);
    start = s; tdone = td; busy = b; valid = v; res = r; addr = a;
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    @(negedge clk);
    #1;
  endtask

  task automatic check_res(input string tag, input res_t act, input res_t exp);
    check({tag, "_error_flg"},   act.eflg, exp.eflg);
    check({tag, "_timeout_flg"}, act.tflg, exp.tflg);
    check({tag, "_first_addr"},  act.addr, exp.addr);
    check({tag, "_error_cnt"},   act.ecnt, exp.ecnt);
    check({tag, "_word_cnt"},    act.wcnt, exp.wcnt);
    check({tag, "_cycle_cnt"},   act.ccnt, exp.ccnt);
  endtask

  function automatic res_t obs_stop();
    res_t r;
    r = '{eflg: s_eflg, tflg: s_tflg, addr: s_addr, ecnt: 16'(s_ecnt), wcnt: s_wcnt, ccnt: s_ccnt};
    return r;
  endfunction

  function automatic res_t obs_cont();
    res_t r;
    r = '{eflg: c_eflg, tflg: c_tflg, addr: c_addr, ecnt: 16'(c_ecnt), wcnt: c_wcnt, ccnt: c_ccnt};
    return r;
  endfunction

  // Monitor: status bits every cycle, full results whenever a completion strobe appears.
  always @(negedge clk) begin
    if (mon_en) begin
      check("stop_busy", s_busy, m[0].phase inside {M_RUN, M_DRAIN});
      check("stop_done", s_done, m[0].phase == M_DONE);
      check("stop_strobe", s_stb, m[0].stb);
      check("cont_busy", c_busy, m[1].phase inside {M_RUN, M_DRAIN});
      check("cont_done", c_done, m[1].phase == M_DONE);
      check("cont_strobe", c_stb, m[1].stb);
      if (s_stb) begin
        stb_cnt[0]++;
        if (q_stop.size() == 0) check("stop_unexpected_done", 1'b1, 1'b0);
        else check_res("stop", obs_stop(), q_stop.pop_front());
      end
      if (c_stb) begin
        stb_cnt[1]++;
        if (q_cont.size() == 0) check("cont_unexpected_done", 1'b1, 1'b0);
        else check_res("cont", obs_cont(), q_cont.pop_front());
      end
    end
  end

  initial begin
    int s0, s1, len;
    bit s, v, r, td;

    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      m[k].phase = M_IDLE;
      m[k].stb   = 0;
    end

    rst = 1'b1;
    repeat (3) cycle(0, 0, 0, 0, 0, '0);
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_stop_results", obs_stop(), '0);
    check("reset_cont_results", obs_cont(), '0);
    check("reset_status", {s_busy, s_done, s_stb, c_busy, c_done, c_stb}, '0);
    // Idle ignores verdicts and trans_done.
    cycle(0, 1, 0, 1, 1, 32'h55);
    check("idle_ignores_verdict", {s_wcnt, c_wcnt, 16'(s_ecnt), 16'(c_ecnt), s_busy}, '0);

    // Clean run: 8 passing verdicts, trans_done on the last, then drain.
    s0 = stb_cnt[0]; s1 = stb_cnt[1];
    cycle(1, 0, 1, 0, 0, '0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cycle(0, 0, 1, 0, 0, '0);
      cycle(0, i == 7, 1, 1, 0, CTRL_ADDR_W'(i * 4));
    end
    cycle(0, 0, 1, 0, 0, '0);
    check("clean_not_done_while_busy", s_done, 1'b0);
    cycle(0, 0, 0, 0, 0, '0);
    check("clean_done", {s_done, c_done}, 2'b11);
    check("clean_words", s_wcnt, 8);
    check("clean_errors", {16'(s_ecnt), s_eflg}, '0);
    check("clean_cycles", c_ccnt, 17);
    check("clean_one_strobe", {stb_cnt[0] - s0, stb_cnt[1] - s1}, {32'd1, 32'd1});
    cycle(0, 0, 0, 0, 0, '0);
    check("clean_strobe_once", {s_stb, c_stb, s_done}, 3'b001);

    // Stop on error at verdict 3, address 0x40; later verdicts ignored.
    cycle(1, 0, 1, 0, 0, '0);
    cycle(0, 0, 1, 1, 0, 32'h0);
    cycle(0, 0, 1, 1, 0, 32'h4);
    cycle(0, 0, 1, 1, 1, 32'h40);
    check("stop_done_next_cycle", {s_done, c_done}, 2'b10);
    check("stop_first_addr", s_addr, 32'h40);
    check("stop_err_cnt", s_ecnt, 1);
    for (int i = 0; i < 3; i++) cycle(0, i == 2, 1, 1, i == 1, 32'h80 + 32'(i));
    cycle(0, 0, 0, 0, 0, '0);
    check("stop_words_held", s_wcnt, 3);
    check("cont_words_after_drain", {c_done, c_wcnt}, {1'b1, 32'd6});
    check("cont_err_cnt_two", {c_addr, 16'(c_ecnt)}, {32'h40, 16'd2});

    // Continue on errors: 0x10, 0x20, 0x30.
    cycle(1, 0, 1, 0, 0, '0);
    cycle(0, 0, 1, 1, 1, 32'h10);
    cycle(0, 0, 1, 1, 0, 32'h14);
    cycle(0, 0, 1, 1, 1, 32'h20);
    cycle(0, 0, 1, 1, 0, 32'h24);
    cycle(0, 1, 1, 1, 1, 32'h30);
    check("cont_still_draining", {c_busy, c_done}, 2'b10);
    cycle(0, 0, 0, 0, 0, '0);
    check("cont_done_after_drain", c_done, 1'b1);
    check("cont_first_addr", c_addr, 32'h10);
    check("cont_err_cnt", c_ecnt, 3);
    check("stop_first_of_three", {s_addr, 16'(s_ecnt)}, {32'h10, 16'd1});

    // Timeout: no verdicts with compare_block busy.
    cycle(1, 0, 1, 0, 0, '0);
    repeat (15) cycle(0, 0, 1, 0, 0, '0);
    check("timeout_not_early", {s_done, c_done}, 2'b00);
    cycle(0, 0, 1, 0, 0, '0);
    check("timeout_done", {s_done, s_tflg, c_done, c_tflg}, 4'b1111);
    check("timeout_cycles", {s_ccnt, c_ccnt}, {32'd16, 32'd16});
    repeat (3) cycle(0, 0, 1, 1, 1, 32'hAA);
    check("done_holds", {s_done, s_ccnt, c_wcnt}, {1'b1, 32'd16, 32'd0});

    // Saturation of the 4-bit error counter.
    cycle(1, 0, 1, 0, 0, '0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 1, 1, CTRL_ADDR_W'(32'h100 + i));
    check("sat_err_cnt", c_ecnt, 15);
    check("sat_words", c_wcnt, 20);
    cycle(0, 1, 1, 0, 0, '0);
    cycle(0, 0, 0, 0, 0, '0);
    check("sat_err_cnt_holds", {c_done, 16'(c_ecnt), c_addr}, {1'b1, 16'd15, 32'h100});

    // Restart coincident with an error verdict.
    cycle(1, 0, 1, 0, 0, '0);
    repeat (3) cycle(0, 0, 1, 1, 0, 32'h8);
    cycle(1, 0, 1, 1, 1, 32'h99);
    check("restart_stop_cleared", obs_stop(), '0);
    check("restart_cont_cleared", obs_cont(), '0);
    check("restart_running", {s_busy, c_busy, s_done}, 3'b110);

    // Reset while draining: back to idle, no strobe.
    s0 = stb_cnt[0]; s1 = stb_cnt[1];
    cycle(0, 1, 1, 0, 0, '0);
    repeat (2) cycle(0, 0, 1, 0, 0, '0);
    rst = 1'b1;
    cycle(0, 0, 0, 0, 0, '0);
    rst = 1'b0;
    cycle(0, 0, 0, 0, 0, '0);
    check("reset_in_drain_results", {obs_stop(), s_busy, s_done}, '0);
    check("reset_in_drain_no_strobe", {stb_cnt[0] - s0, stb_cnt[1] - s1}, '0);

    // Randomized tests.
    for (int t = 0; t < 60; t++) begin
      cycle(1, 0, 1, 0, 0, '0);
      len = int'($urandom_range(4, 30));
      for (int j = 0; j < len; j++) begin
        if ($urandom % 25 == 0) repeat (TO + 2) cycle(0, 0, 1, 0, 0, '0);
        s  = ($urandom % 60 == 0);
        v  = ($urandom % 3 != 0);
        r  = ($urandom % 8 == 0);
        td = (j == len - 1);
        cycle(s, td, 1, v, r, CTRL_ADDR_W'($urandom));
      end
      for (int k = 0; k < 40 && !(m[0].phase == M_DONE && m[1].phase == M_DONE); k++) begin
        v = ($urandom % 4 == 0);
        r = ($urandom % 6 == 0);
        cycle(0, 0, ($urandom % 3 != 0), v, r, CTRL_ADDR_W'($urandom));
      end
    end
    repeat (2) cycle(0, 0, 0, 0, 0, '0);

    check("stop_queue_empty", q_stop.size(), 0);
    check("cont_queue_empty", q_cont.size(), 0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_block.md
Name: result_block

Overview:
- Final stage of the memory checker datapath; sits directly downstream of compare_block.
- Consumes the per-word check verdicts and drives the test state machine (idle/run/drain/done).
- Accumulates statistics: checked words, error count, first-error address, test duration, and timeout watchdog.
- Presents stable, CSR-readable results plus a completion strobe to the control block.

Parameters:
- ERR_CNT_W, 16, width of saturating error counter
- STAT_CNT_W, 32, width of saturating word and cycle counters
- TIMEOUT_CYCLES, 4096, cycles with no verdict in RUN/DRAIN before a timeout is declared
- STOP_ON_ERROR, 1, 1: first error ends the test; 0: run to completion and count all errors

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_test_i  in  1  pulse, (re)starts a test from any state
- trans_done_stb_i  in  1  pulse from transmitter: last read command issued
- cmp_busy_i  in  1  compare_block holds or is processing a packet
- check_result_valid_i  in  1  one pulse per checked word
- check_result_i  in  1  1 = mismatch on that word; qualified by valid
- check_error_address_i  in  CTRL_ADDR_W  byte address of mismatch; qualified by valid & result
- test_busy_o  out  1  state is RUN or DRAIN
- test_done_o  out  1  state is DONE (level)
- test_done_stb_o  out  1  one-cycle pulse on entry to DONE
- error_flg_o  out  1  sticky: at least one error this test
- timeout_flg_o  out  1  sticky: test ended by watchdog
- first_error_addr_o  out  CTRL_ADDR_W  address of first error this test
- error_cnt_o  out  ERR_CNT_W  saturating error count
- checked_word_cnt_o  out  STAT_CNT_W  saturating count of valid verdicts
- test_cycle_cnt_o  out  STAT_CNT_W  saturating cycles spent in RUN+DRAIN

Behaviour:
- Reset: state IDLE; all outputs 0.
- All outputs registered; each reflects its input event one cycle later.
- States: IDLE, RUN, DRAIN, DONE.
  - Any state + start_test_i -> RUN. All counters, flags and first_error_addr_o clear in the same edge.
  - start_test_i has priority over every other event in that cycle; the verdict in that cycle is discarded.
  - RUN + trans_done_stb_i -> DRAIN.
  - DRAIN + !cmp_busy_i -> DONE, evaluated one cycle after entering DRAIN so compare_block busy is settled.
  - RUN/DRAIN + error verdict + STOP_ON_ERROR=1 -> DONE immediately; overrides trans_done_stb_i and drain.
  - RUN/DRAIN + idle_cnt == TIMEOUT_CYCLES-1 with no verdict this cycle -> DONE, timeout_flg_o=1.
  - DONE holds until start_test_i. IDLE exits only on start_test_i.
- Verdicts are accepted only in RUN/DRAIN. In IDLE/DONE they are ignored, including late words after a stop.
- Accepted verdict handling:
  - checked_word_cnt_o += 1.
  - If check_result_i: error_cnt_o += 1, error_flg_o <= 1.
  - If this is the first error of the test (error_flg_o == 0): latch check_error_address_i into first_error_addr_o; later errors never overwrite it.
- Counters saturate at all-ones, no wrap. Verify for error_cnt_o with ERR_CNT_W reduced to 4.
- idle_cnt (internal, clog2(TIMEOUT_CYCLES) bits):
  - clears on start and on every accepted verdict;
  - increments in RUN/DRAIN;
  - held in IDLE/DONE.
- test_cycle_cnt_o increments each cycle in RUN/DRAIN, including the cycle that transitions to DONE.
- test_done_stb_o asserts exactly once per test, in the cycle test_done_o first rises.
- Simultaneous trans_done_stb_i and last verdict: both take effect; the verdict is counted.
- Reset mid-test returns to IDLE with cleared results; no strobe is produced.

Decomposition:
- settings_pkg: add the result_state_t enum (IDLE/RUN/DRAIN/DONE) and a result_struct_t bundling the flags, counters and address for the CSR block; reuse CTRL_ADDR_W.
- Parameter defaults live in settings_pkg as localparams.
- One natural sub-module: sat_counter (parameterized width, clear, inc, saturating), instantiated for the error, word and cycle counters.

Test Plan:
- Clean run: start, 8 verdicts all pass, trans_done_stb, cmp_busy drops -> test_done_stb_o once; checked_word_cnt_o=8, error_cnt_o=0, error_flg_o=0.
- Stop on error: STOP_ON_ERROR=1, error at verdict 3, addr 0x0040 -> DONE next cycle; first_error_addr_o=0x0040, error_cnt_o=1; later verdicts ignored, checked_word_cnt_o stays 3.
- Continue on errors: STOP_ON_ERROR=0, errors at 0x10, 0x20, 0x30 -> first_error_addr_o=0x10, error_cnt_o=3; DONE only after drain.
- Timeout: TIMEOUT_CYCLES=16, start, no verdicts, cmp_busy_i=1 -> DONE on the 16th cycle after start with timeout_flg_o=1; test_cycle_cnt_o=16.
- Saturation: ERR_CNT_W=4, STOP_ON_ERROR=0, 20 error verdicts -> error_cnt_o=15 and holds.
- Restart priority: start_test_i coincident with an error verdict mid-run -> state RUN, all results 0, verdict not counted; reset asserted in DRAIN -> IDLE, no test_done_stb_o.
